wb_stage_ctrl: RTL and testbench

Registered writeback stage for the RV32I pipeline; successor to the combinational writeback decoder. It accepts one retiring instruction per cycle from MEM and decodes the opcode into a write enable and a data source (ALU, PC+4, load). It waits on a variable-latency data-memory response, aligns and sign-extends load data, and drives the register-file write port. It also reports the pending load destination for load-use hazard detection, and supports flush and a load-response timeout.

---
 rtl/rv32i_pkg.sv | 60 ++++++
 rtl/wb_stage_ctrl_load_align.sv | 60 ++++++
 rtl/wb_stage_ctrl.sv | 173 +++++++++++++++++
 tb/tb_wb_stage_ctrl.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions: opcodes, load funct3 codes, writeback-source
// enum and the opcode -> writeback decode used by the writeback stage.
package rv32i_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

  // Encoding is shared with the existing combinational decoder.
  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC4 = 2'd2
  } wb_src_e;

  typedef struct packed {
    logic    we;
    wb_src_e src;
  } wb_dec_t;

  typedef enum logic {
    ST_IDLE,
    ST_WAIT_LOAD
  } wb_state_e;

  // Opcode-only decode; the rd==x0 suppression is applied by the caller.
  function automatic wb_dec_t decode_wb(input logic [6:0] opcode);
    wb_dec_t d;
    d.we  = 1'b0;
    d.src = WB_ALU;
    case (opcode)
      OPC_LUI, OPC_AUIPC, OPC_OPIMM, OPC_OP: d.we = 1'b1;
      OPC_JAL, OPC_JALR: begin
        d.we  = 1'b1;
        d.src = WB_PC4;
      end
      OPC_LOAD: begin
        d.we  = 1'b1;
        d.src = WB_MEM;
      end
      default: d.we = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/wb_stage_ctrl_load_align.sv
// Combinational load formatter: selects the byte lane from addr_lo,
// sign/zero-extends to XLEN and flags funct3 codes illegal for this XLEN.
module load_align
  import rv32i_pkg::*;
#(
  parameter  int XLEN = 32,
  localparam int AW   = $clog2(XLEN / 8)
) (
  input  logic [2:0]      funct3,
  input  logic [AW-1:0]   addr_lo,
  input  logic [XLEN-1:0] rdata,
  output logic [XLEN-1:0] data,
  output logic            illegal
);

  // Halfword and word accesses ignore the low offset bits below their size;
  // at XLEN=32 the word lane mask clears every offset bit.
  logic [AW-1:0]   h_lane;
  logic [AW-1:0]   w_lane;
  logic [XLEN-1:0] b_sh;
  logic [XLEN-1:0] h_sh;
  logic [XLEN-1:0] w_sh;
  logic [7:0]      b_val;
  logic [15:0]     h_val;
  logic [31:0]     w_val;

  assign h_lane = addr_lo & ~AW'(1);
  assign w_lane = addr_lo & ~AW'(3);
  assign b_sh   = rdata >> {addr_lo, 3'b000};
  assign h_sh   = rdata >> {h_lane, 3'b000};
  assign w_sh   = rdata >> {w_lane, 3'b000};
  assign b_val  = b_sh[7:0];
  assign h_val  = h_sh[15:0];
  assign w_val  = w_sh[31:0];

  // Extension per funct3; 64-bit-only codes are illegal at XLEN=32.
  always_comb begin
    // NOTE: every output gets a default first so no path through the case
    // leaves it unassigned, which would otherwise infer a latch.
    data    = '0;
    illegal = 1'b0;
    case (funct3)
      F3_LB:  data = XLEN'($signed(b_val));
      F3_LH:  data = XLEN'($signed(h_val));
      F3_LW:  data = XLEN'($signed(w_val));
      F3_LBU: data = XLEN'(b_val);
      F3_LHU: data = XLEN'(h_val);
      F3_LWU: begin
        if (XLEN == 64) data = XLEN'(w_val);
        else illegal = 1'b1;
      end
      F3_LD: begin
        if (XLEN == 64) data = rdata;
        else illegal = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/wb_stage_ctrl.sv
// Registered writeback stage: decodes the retiring instruction, waits for a
// variable-latency load response, formats load data and drives the register
// file write port. Reports the outstanding load rd for hazard detection.
module wb_stage_ctrl
  import rv32i_pkg::*;
#(
  parameter  int XLEN          = 32,
  parameter  int MAX_LOAD_WAIT = 15,
  localparam int AW            = $clog2(XLEN / 8)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [6:0]      opcode,
  input  logic [2:0]      funct3,
  input  logic [4:0]      rd,
  input  logic [XLEN-1:0] alu_result,
  input  logic [XLEN-1:0] pc_plus4,
  input  logic [AW-1:0]   addr_lo,
  input  logic            dmem_rvalid,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            rf_we,
  output logic [4:0]      rf_waddr,
  output logic [XLEN-1:0] rf_wdata,
  output logic            pend_valid,
  output logic [4:0]      pend_rd,
  output logic            err
);

  localparam int            CW       = $clog2(MAX_LOAD_WAIT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(MAX_LOAD_WAIT - 1);

  wb_state_e       state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      f3_q, f3_d;
  logic [4:0]      rd_q, rd_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic            rf_we_q, rf_we_d;
  logic [4:0]      rf_waddr_q, rf_waddr_d;
  logic [XLEN-1:0] rf_wdata_q, rf_wdata_d;
  logic            err_q, err_d;

  wb_dec_t         dec;
  logic            accept;
  logic            load_acc;
  logic            timeout;
  logic [2:0]      align_f3;
  logic [XLEN-1:0] align_data;
  logic            align_illegal;

  assign dec      = decode_wb(opcode);
  assign in_ready = (state_q == ST_IDLE);
  assign accept   = in_valid && in_ready && !flush;
  assign load_acc = accept && (dec.src == WB_MEM);
  // Last permitted waiting cycle passed with no response.
  assign timeout  = (state_q == ST_WAIT_LOAD) && !dmem_rvalid && (cnt_q == CNT_LAST);

  // The aligner checks legality of the incoming funct3 while idle and
  // formats the response with the latched funct3 while waiting.
  assign align_f3 = (state_q == ST_IDLE) ? funct3 : f3_q;

  load_align #(.XLEN(XLEN)) u_load_align (
    .funct3  (align_f3),
    .addr_lo (addr_q),
    .rdata   (dmem_rdata),
    .data    (align_data),
    .illegal (align_illegal)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic: flush, response and timeout all end the wait.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:      if (load_acc && !align_illegal) state_d = ST_WAIT_LOAD;
      ST_WAIT_LOAD: if (flush || dmem_rvalid || timeout) state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  // Output/datapath logic: write port, error pulse, wait counter, latches.
  always_comb begin
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    err_d      = 1'b0;
    cnt_d      = cnt_q;
    f3_d       = f3_q;
    rd_d       = rd_q;
    addr_d     = addr_q;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (accept) begin
          if (dec.src == WB_MEM) begin
            if (align_illegal) begin
              err_d = 1'b1;
            end else begin
              f3_d   = funct3;
              rd_d   = rd;
              addr_d = addr_lo;
            end
          end else if (dec.we && (rd != 5'd0)) begin
            rf_we_d    = 1'b1;
            rf_waddr_d = rd;
            rf_wdata_d = (dec.src == WB_PC4) ? pc_plus4 : alu_result;
          end
        end
      end
      ST_WAIT_LOAD: begin
        if (flush) begin
          cnt_d = '0;
        end else if (dmem_rvalid) begin
          cnt_d = '0;
          // x0 loads still wait for ordering but never write.
          if (rd_q != 5'd0) begin
            rf_we_d    = 1'b1;
            rf_waddr_d = rd_q;
            rf_wdata_d = align_data;
          end
        end else if (timeout) begin
          cnt_d = '0;
          err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: cnt_d = '0;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: every register here is a plain flop with a defined reset value;
    // there is no storage array, so nothing is left unreset.
    if (!rst_n) begin
      cnt_q      <= '0;
      f3_q       <= '0;
      rd_q       <= '0;
      addr_q     <= '0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      err_q      <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      f3_q       <= f3_d;
      rd_q       <= rd_d;
      addr_q     <= addr_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      err_q      <= err_d;
    end
  end

  assign rf_we      = rf_we_q;
  assign rf_waddr   = rf_waddr_q;
  assign rf_wdata   = rf_wdata_q;
  assign err        = err_q;
  assign pend_valid = (state_q == ST_WAIT_LOAD);
  assign pend_rd    = rd_q;

endmodule

// File: tb/tb_wb_stage_ctrl.sv
// Bench for wb_stage_ctrl: one XLEN=32 and one XLEN=64 instance share the
// same stimulus; both are compared every cycle against a behavioural model.
module tb_wb_stage_ctrl;

  localparam int MAXW = 5;

  localparam logic [6:0] T_LUI    = 7'b0110111;
  localparam logic [6:0] T_AUIPC  = 7'b0010111;
  localparam logic [6:0] T_JAL    = 7'b1101111;
  localparam logic [6:0] T_JALR   = 7'b1100111;
  localparam logic [6:0] T_BRANCH = 7'b1100011;
  localparam logic [6:0] T_LOAD   = 7'b0000011;
  localparam logic [6:0] T_STORE  = 7'b0100011;
  localparam logic [6:0] T_OPIMM  = 7'b0010011;
  localparam logic [6:0] T_OP     = 7'b0110011;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush, in_valid, dmem_rvalid;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [4:0]  rd;
  logic [63:0] alu_result, pc_plus4, dmem_rdata;
  logic [2:0]  addr_lo;

  logic        in_ready32, rf_we32, pend_valid32, err32;
  logic [4:0]  rf_waddr32, pend_rd32;
  logic [31:0] rf_wdata32;
  logic        in_ready64, rf_we64, pend_valid64, err64;
  logic [4:0]  rf_waddr64, pend_rd64;
  logic [63:0] rf_wdata64;

  int n_cmp = 0;
  int n_bad = 0;

  // Model state, index 0 = XLEN 32, index 1 = XLEN 64.
  bit          m_pend[2];
  logic [2:0]  m_f3[2];
  logic [4:0]  m_rd[2];
  logic [2:0]  m_addr[2];
  int          m_wait[2];
  logic        m_we[2];
  logic        m_err[2];
  logic [4:0]  m_waddr[2];
  logic [63:0] m_wdata[2];

  always #5 clk = ~clk;

  wb_stage_ctrl #(.XLEN(32), .MAX_LOAD_WAIT(MAXW)) dut32 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
    .in_ready(in_ready32), .opcode(opcode), .funct3(funct3), .rd(rd),
    .alu_result(alu_result[31:0]), .pc_plus4(pc_plus4[31:0]),
    .addr_lo(addr_lo[1:0]), .dmem_rvalid(dmem_rvalid),
    .dmem_rdata(dmem_rdata[31:0]), .rf_we(rf_we32), .rf_waddr(rf_waddr32),
    .rf_wdata(rf_wdata32), .pend_valid(pend_valid32), .pend_rd(pend_rd32),
    .err(err32)
  );

  wb_stage_ctrl #(.XLEN(64), .MAX_LOAD_WAIT(MAXW)) dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
    .in_ready(in_ready64), .opcode(opcode), .funct3(funct3), .rd(rd),
    .alu_result(alu_result), .pc_plus4(pc_plus4), .addr_lo(addr_lo),
    .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata), .rf_we(rf_we64),
    .rf_waddr(rf_waddr64), .rf_wdata(rf_wdata64), .pend_valid(pend_valid64),
    .pend_rd(pend_rd64), .err(err64)
  );

  function automatic bit legal_f3(int xlen, logic [2:0] f3);
    if (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) return 1'b1;
    return (xlen == 64) && (f3 inside {3'd3, 3'd6});
  endfunction

  // Load result from access size, signedness and naturally aligned lane.
  function automatic logic [63:0] fmt(int xlen, logic [2:0] f3, logic [2:0] addr,
                                      logic [63:0] raw);
    logic [63:0] word, v, mask;
    int size, a, lane;
    bit sgn;
    word = (xlen == 32) ? {32'h0, raw[31:0]} : raw;
    a    = int'(addr) % (xlen / 8);
    case (f3)
      3'd0: begin size = 1; sgn = 1; end
      3'd1: begin size = 2; sgn = 1; end
      3'd2: begin size = 4; sgn = 1; end
      3'd3: begin size = 8; sgn = 0; end
      3'd4: begin size = 1; sgn = 0; end
      3'd5: begin size = 2; sgn = 0; end
      default: begin size = 4; sgn = 0; end
    endcase
    lane = a - (a % size);
    v = word >> (8 * lane);
    if (size < 8) begin
      mask = (64'd1 << (8 * size)) - 64'd1;
      v = v & mask;
      if (sgn && v[8 * size - 1]) v = v | ~mask;
    end
    if (xlen == 32) v = v & 64'hFFFF_FFFF;
    return v;
  endfunction

  task automatic model_reset();
    for (int x = 0; x < 2; x++) begin
      m_pend[x] = 0; m_f3[x] = 0; m_rd[x] = 0; m_addr[x] = 0; m_wait[x] = 0;
      m_we[x] = 0; m_err[x] = 0; m_waddr[x] = 0; m_wdata[x] = 0;
    end
  endtask

  // Advance the model by one cycle using the inputs currently driven.
  task automatic model_step();
    for (int x = 0; x < 2; x++) begin
      int xlen;
      logic [63:0] m;
      xlen = (x == 0) ? 32 : 64;
      m = (xlen == 32) ? 64'hFFFF_FFFF : '1;
      m_we[x] = 0;
      m_err[x] = 0;
      if (!m_pend[x]) begin
        if (in_valid && !flush) begin
          if (opcode == T_LOAD) begin
            if (!legal_f3(xlen, funct3)) m_err[x] = 1;
            else begin
              m_pend[x] = 1; m_f3[x] = funct3; m_rd[x] = rd;
              m_addr[x] = addr_lo; m_wait[x] = 0;
            end
          end else if (rd != 0 && opcode inside {T_LUI, T_AUIPC, T_OPIMM, T_OP}) begin
            m_we[x] = 1; m_waddr[x] = rd; m_wdata[x] = alu_result & m;
          end else if (rd != 0 && opcode inside {T_JAL, T_JALR}) begin
            m_we[x] = 1; m_waddr[x] = rd; m_wdata[x] = pc_plus4 & m;
          end
        end
      end else if (flush) begin
        m_pend[x] = 0;
      end else if (dmem_rvalid) begin
        m_pend[x] = 0;
        if (m_rd[x] != 0) begin
          m_we[x] = 1; m_waddr[x] = m_rd[x];
          m_wdata[x] = fmt(xlen, m_f3[x], m_addr[x], dmem_rdata);
        end
      end else begin
        m_wait[x]++;
        if (m_wait[x] == MAXW) begin
          m_pend[x] = 0; m_err[x] = 1;
        end
      end
    end
  endtask

  // One clock: update model, cross the edge, compare both instances.
  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    for (int x = 0; x < 2; x++) begin
      logic a_rdy, a_we, a_pv, a_err;
      logic [4:0] a_wa, a_prd;
      logic [63:0] a_wd;
      a_rdy = x ? in_ready64 : in_ready32;
      a_we  = x ? rf_we64 : rf_we32;
      a_pv  = x ? pend_valid64 : pend_valid32;
      a_err = x ? err64 : err32;
      a_wa  = x ? rf_waddr64 : rf_waddr32;
      a_prd = x ? pend_rd64 : pend_rd32;
      a_wd  = x ? rf_wdata64 : {32'h0, rf_wdata32};
      n_cmp += 7;
      if (a_rdy !== !m_pend[x]) begin
        n_bad++; $display("FAIL in_ready[x%0d] t=%0t: got %b want %b", x, $time, a_rdy, !m_pend[x]);
      end
      if (a_we !== m_we[x]) begin
        n_bad++; $display("FAIL rf_we[x%0d] t=%0t: got %b want %b", x, $time, a_we, m_we[x]);
      end
      if (a_pv !== m_pend[x]) begin
        n_bad++; $display("FAIL pend_valid[x%0d] t=%0t: got %b want %b", x, $time, a_pv, m_pend[x]);
      end
      if (a_err !== m_err[x]) begin
        n_bad++; $display("FAIL err[x%0d] t=%0t: got %b want %b", x, $time, a_err, m_err[x]);
      end
      if (a_wa !== m_waddr[x]) begin
        n_bad++; $display("FAIL rf_waddr[x%0d] t=%0t: got %0d want %0d", x, $time, a_wa, m_waddr[x]);
      end
      if (a_prd !== m_rd[x]) begin
        n_bad++; $display("FAIL pend_rd[x%0d] t=%0t: got %0d want %0d", x, $time, a_prd, m_rd[x]);
      end
      if (a_wd !== m_wdata[x]) begin
        n_bad++; $display("FAIL rf_wdata[x%0d] t=%0t: got %h want %h", x, $time, a_wd, m_wdata[x]);
      end
    end
  endtask

  task automatic drive_idle();
    flush = 0; in_valid = 0; dmem_rvalid = 0; opcode = T_BRANCH; funct3 = 0;
    rd = 0; alu_result = 0; pc_plus4 = 0; addr_lo = 0; dmem_rdata = 0;
  endtask

  task automatic issue(logic [6:0] opc, logic [2:0] f3, logic [4:0] r);
    drive_idle();
    in_valid = 1; opcode = opc; funct3 = f3; rd = r;
  endtask

  task automatic test_reset();
    drive_idle();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({rf_we32, err32, pend_valid32, rf_waddr32, pend_rd32, rf_wdata32, in_ready32} !== {45'd0, 1'b1}) begin
      n_bad++;
      $display("FAIL reset_state: got we=%b err=%b pv=%b wa=%0d prd=%0d wd=%h rdy=%b, want 0s and rdy=1",
               rf_we32, err32, pend_valid32, rf_waddr32, pend_rd32, rf_wdata32, in_ready32);
    end
    rst_n = 1;
    model_reset();
  endtask

  task automatic test_alu_write();
    issue(T_OPIMM, 3'b000, 5'd5);
    alu_result = 64'h7;
    step();
    n_cmp++;
    if (rf_we32 !== 1'b1 || rf_waddr32 !== 5'd5 || rf_wdata32 !== 32'h7) begin
      n_bad++; $display("FAIL addi_write: got we=%b wa=%0d wd=%h want 1/5/00000007", rf_we32, rf_waddr32, rf_wdata32);
    end
    drive_idle();
    step();
    n_cmp++;
    if (rf_we32 !== 1'b0) begin
      n_bad++; $display("FAIL addi_one_cycle: got we=%b want 0", rf_we32);
    end
    // Flush while idle blocks acceptance.
    issue(T_OP, 3'b000, 5'd9);
    flush = 1; alu_result = 64'h55;
    step();
    n_cmp++;
    if (rf_we32 !== 1'b0) begin
      n_bad++; $display("FAIL flush_idle_block: got we=%b want 0", rf_we32);
    end
  endtask

  task automatic test_link_and_nowrite();
    issue(T_JAL, 3'b000, 5'd1);
    pc_plus4 = 64'h104;
    step();
    n_cmp++;
    if (rf_we32 !== 1'b1 || rf_wdata32 !== 32'h104) begin
      n_bad++; $display("FAIL jal_link: got we=%b wd=%h want 1/00000104", rf_we32, rf_wdata32);
    end
    issue(T_STORE, 3'b010, 5'd2);
    step();
    issue(T_BRANCH, 3'b000, 5'd3);
    step();
    n_cmp++;
    if (rf_we32 !== 1'b0) begin
      n_bad++; $display("FAIL branch_nowrite: got we=%b want 0", rf_we32);
    end
    issue(T_LUI, 3'b000, 5'd0);
    alu_result = 64'hDEAD_0000;
    step();
    n_cmp++;
    if (rf_we32 !== 1'b0 || rf_wdata32 !== 32'h104) begin
      n_bad++; $display("FAIL lui_x0: got we=%b wd=%h want 0/00000104", rf_we32, rf_wdata32);
    end
  endtask

  task automatic load_byte(logic [2:0] f3, logic [31:0] want);
    issue(T_LOAD, f3, 5'd3);
    addr_lo = 3'd2;
    step();
    drive_idle();
    for (int i = 0; i < 2; i++) begin
      step();
      n_cmp++;
      if (in_ready32 !== 1'b0 || pend_valid32 !== 1'b1 || pend_rd32 !== 5'd3) begin
        n_bad++; $display("FAIL load_pending: got rdy=%b pv=%b prd=%0d want 0/1/3", in_ready32, pend_valid32, pend_rd32);
      end
    end
    dmem_rvalid = 1; dmem_rdata = 64'h0000_0000_0080_0000;
    step();
    dmem_rvalid = 0;
    n_cmp++;
    if (rf_we32 !== 1'b1 || rf_waddr32 !== 5'd3 || rf_wdata32 !== want || in_ready32 !== 1'b1) begin
      n_bad++; $display("FAIL load_byte_f3_%0d: got we=%b wa=%0d wd=%h rdy=%b want 1/3/%h/1",
                        f3, rf_we32, rf_waddr32, rf_wdata32, in_ready32, want);
    end
  endtask

  task automatic test_load_sign();
    load_byte(3'b000, 32'hFFFF_FF80);
    load_byte(3'b100, 32'h0000_0080);
  endtask

  task automatic test_timeout();
    issue(T_LOAD, 3'b010, 5'd4);
    step();
    drive_idle();
    for (int i = 0; i < MAXW - 1; i++) step();
    n_cmp++;
    if (err32 !== 1'b0 || pend_valid32 !== 1'b1) begin
      n_bad++; $display("FAIL timeout_early: got err=%b pv=%b want 0/1", err32, pend_valid32);
    end
    step();
    n_cmp++;
    if (err32 !== 1'b1 || rf_we32 !== 1'b0 || in_ready32 !== 1'b1) begin
      n_bad++; $display("FAIL timeout_pulse: got err=%b we=%b rdy=%b want 1/0/1", err32, rf_we32, in_ready32);
    end
    dmem_rvalid = 1; dmem_rdata = 64'h1234_5678;
    step();
    dmem_rvalid = 0;
    n_cmp++;
    if (rf_we32 !== 1'b0 || err32 !== 1'b0) begin
      n_bad++; $display("FAIL stale_rvalid: got we=%b err=%b want 0/0", rf_we32, err32);
    end
  endtask

  task automatic test_flush_vs_rvalid();
    issue(T_LOAD, 3'b001, 5'd6);
    addr_lo = 3'd2;
    step();
    drive_idle();
    step();
    flush = 1; dmem_rvalid = 1; dmem_rdata = 64'hAAAA_BBBB;
    step();
    n_cmp++;
    if (rf_we32 !== 1'b0 || err32 !== 1'b0 || pend_valid32 !== 1'b0) begin
      n_bad++; $display("FAIL flush_wins: got we=%b err=%b pv=%b want 0/0/0", rf_we32, err32, pend_valid32);
    end
    flush = 0;
    step();
    drive_idle();
    n_cmp++;
    if (rf_we32 !== 1'b0) begin
      n_bad++; $display("FAIL rvalid_after_flush: got we=%b want 0", rf_we32);
    end
  endtask

  task automatic test_reset_mid_wait();
    issue(T_LOAD, 3'b000, 5'd12);
    step();
    drive_idle();
    step();
    #2 rst_n = 0;
    #1;
    n_cmp++;
    if (pend_valid32 !== 1'b0 || pend_rd32 !== 5'd0 || in_ready32 !== 1'b1 ||
        rf_wdata32 !== 32'd0 || rf_waddr32 !== 5'd0 || pend_valid64 !== 1'b0) begin
      n_bad++; $display("FAIL async_reset_mid_wait: got pv=%b prd=%0d rdy=%b wd=%h wa=%0d pv64=%b",
                        pend_valid32, pend_rd32, in_ready32, rf_wdata32, rf_waddr32, pend_valid64);
    end
    @(posedge clk);
    #1 rst_n = 1;
    model_reset();
  endtask

  task automatic test_funct3_xlen();
    issue(T_LOAD, 3'b011, 5'd7);
    step();
    drive_idle();
    n_cmp++;
    if (err32 !== 1'b1 || in_ready32 !== 1'b1 || rf_we32 !== 1'b0 || pend_valid64 !== 1'b1 || err64 !== 1'b0) begin
      n_bad++; $display("FAIL ld_legality: got err32=%b rdy32=%b we32=%b pv64=%b err64=%b want 1/1/0/1/0",
                        err32, in_ready32, rf_we32, pend_valid64, err64);
    end
    dmem_rvalid = 1; dmem_rdata = 64'h8000_0000_0000_0001;
    step();
    dmem_rvalid = 0;
    n_cmp++;
    if (rf_we64 !== 1'b1 || rf_wdata64 !== 64'h8000_0000_0000_0001 || rf_we32 !== 1'b0) begin
      n_bad++; $display("FAIL ld_x64: got we64=%b wd64=%h we32=%b want 1/8000000000000001/0",
                        rf_we64, rf_wdata64, rf_we32);
    end
  endtask

  task automatic test_random();
    logic [6:0] opcs [11];
    opcs = '{T_LUI, T_AUIPC, T_JAL, T_JALR, T_BRANCH, T_LOAD, T_LOAD, T_STORE, T_OPIMM, T_OP, 7'h7F};
    for (int i = 0; i < 600; i++) begin
      in_valid    = ($urandom_range(0, 9) < 7);
      flush       = ($urandom_range(0, 11) == 0);
      dmem_rvalid = ($urandom_range(0, 2) == 0);
      opcode      = opcs[$urandom_range(0, 10)];
      funct3      = 3'($urandom_range(0, 7));
      rd          = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      addr_lo     = 3'($urandom_range(0, 7));
      alu_result  = {$urandom, $urandom};
      pc_plus4    = {$urandom, $urandom};
      dmem_rdata  = {$urandom, $urandom};
      step();
    end
    drive_idle();
  endtask

  initial begin
    drive_idle();
    rst_n = 1;
    model_reset();
    test_reset();
    test_alu_write();
    test_link_and_nowrite();
    test_load_sign();
    test_timeout();
    test_flush_vs_rvalid();
    test_reset_mid_wait();
    test_funct3_xlen();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
